// File: rtl/ddc_pkg.sv
// Shared DDC definitions: register map, CTRL bit positions, control states and
// default widths used by both the DDC datapath and its controller.
package ddc_pkg;

  localparam int FSZ_DEFAULT = 26;
  localparam int OSZ_DEFAULT = 16;

  localparam logic [1:0] DDC_REG_CTRL   = 2'd0;
  localparam logic [1:0] DDC_REG_FREQ   = 2'd1;
  localparam logic [1:0] DDC_REG_SETTLE = 2'd2;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_NS_EN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } ddc_state_t;

endpackage

// File: rtl/ddc_out_fifo.sv
// Two-entry first-word-fall-through output buffer; pushes arriving while full
// (and not draining) are dropped and flagged on ovf for one cycle.
module ddc_out_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         ovf
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic [1:0]   count;
  logic         pop;
  logic         accept;

  // Handshake: a word transfers on any cycle where m_valid and m_ready are both high.
  assign m_valid = (count != 2'd0);
  assign m_data  = mem0;
  assign pop     = m_valid && m_ready;
  assign accept  = push && ((count != 2'd2) || pop);
  assign ovf     = push && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, accept} - {1'b0, pop};
      if (pop) begin
        if (count == 2'd2) begin
          mem0 <= mem1;
          if (accept) mem1 <= din;
        end else if (accept) begin
          mem0 <= din;
        end
      end else if (accept) begin
        if (count == 2'd0) mem0 <= din;
        else               mem1 <= din;
      end
    end
  end

endmodule

// File: rtl/ddc_ctrl.sv
// DDC controller: host registers, reset/settle/run sequencing of the DDC and
// buffering of its I/Q output toward the downstream packer.
module ddc_ctrl
  import ddc_pkg::*;
#(
  parameter int FSZ            = FSZ_DEFAULT,
  parameter int OSZ            = OSZ_DEFAULT,
  parameter int RST_CYC        = 4,
  parameter int SETTLE_DEFAULT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             ddc_reset,
  output logic [FSZ-1:0]   ddc_lo_freq,
  output logic             ddc_lo_ns_en,
  input  logic             ddc_out_valid,
  input  logic [OSZ-1:0]   ddc_out_i,
  input  logic [OSZ-1:0]   ddc_out_q,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2*OSZ-1:0] m_data,
  output logic [15:0]      ovf_cnt,
  output logic             busy
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  ddc_state_t     state_q, state_d;
  logic [RCW-1:0] rst_cnt;
  logic [7:0]     settle_cnt;
  logic [7:0]     settle_reg;
  logic [FSZ-1:0] freq_q;
  logic           ns_en_q;
  logic           settle_load;
  logic           wr_ctrl, wr_freq, wr_settle;
  logic           disable_wr, retune_wr, ovf_clr;
  logic           push, flush, ovf;
  logic           unused_wdata;

  assign wr_ctrl    = cfg_wr && (cfg_addr == DDC_REG_CTRL);
  assign wr_freq    = cfg_wr && (cfg_addr == DDC_REG_FREQ);
  assign wr_settle  = cfg_wr && (cfg_addr == DDC_REG_SETTLE);
  assign disable_wr = wr_ctrl && !cfg_wdata[CTRL_ENABLE];
  assign ovf_clr    = wr_ctrl && cfg_wdata[CTRL_OVF_CLR];
  // A retune is a new tuning word or a change of the noise-shaping setting.
  assign retune_wr  = wr_freq ||
                      (wr_ctrl && cfg_wdata[CTRL_ENABLE] && (cfg_wdata[CTRL_NS_EN] != ns_en_q));
  assign unused_wdata = ^cfg_wdata;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    settle_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && cfg_wdata[CTRL_ENABLE]) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (rst_cnt == RCW'(RST_CYC - 1)) begin
          state_d     = ST_SETTLE;
          settle_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (retune_wr)                                     settle_load = 1'b1;
        else if (settle_cnt == 8'd0)                       state_d = ST_RUN;
        else if (ddc_out_valid && (settle_cnt == 8'd1))    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (retune_wr) begin
          state_d     = ST_SETTLE;
          settle_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && disable_wr) begin
      state_d     = ST_IDLE;
      settle_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt    <= '0;
      settle_cnt <= 8'd0;
      settle_reg <= 8'(SETTLE_DEFAULT);
      freq_q     <= '0;
      ns_en_q    <= 1'b0;
      ovf_cnt    <= 16'd0;
    end else begin
      rst_cnt <= (state_q == ST_RESET) ? rst_cnt + 1'b1 : '0;
      if (settle_load)
        settle_cnt <= settle_reg;
      else if ((state_q == ST_SETTLE) && ddc_out_valid && (settle_cnt != 8'd0))
        settle_cnt <= settle_cnt - 8'd1;
      if (wr_settle) settle_reg <= cfg_wdata[7:0];
      if (wr_freq)   freq_q     <= cfg_wdata[FSZ-1:0];
      if (wr_ctrl)   ns_en_q    <= cfg_wdata[CTRL_NS_EN];
      // Clearing takes priority over a drop in the same cycle.
      if (ovf_clr)                       ovf_cnt <= 16'd0;
      else if (ovf && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign ddc_reset    = (state_q == ST_IDLE) || (state_q == ST_RESET);
  assign busy         = (state_q == ST_RESET) || (state_q == ST_SETTLE);
  assign ddc_lo_freq  = freq_q;
  assign ddc_lo_ns_en = ns_en_q;

  // Samples coinciding with a retune or disable belong to the old configuration.
  assign push  = (state_q == ST_RUN) && ddc_out_valid && !retune_wr && !disable_wr;
  assign flush = (state_q != ST_IDLE) && (state_d == ST_IDLE);

  ddc_out_fifo #(.W(2*OSZ)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .din     ({ddc_out_i, ddc_out_q}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .ovf     (ovf)
  );

endmodule

// File: tb/tb_ddc_ctrl.sv
// Directed-sequence bench for ddc_ctrl with random sample payloads, checked
// against a transaction-level model of settle counting, buffering and drops.
module tb_ddc_ctrl;
  import ddc_pkg::*;

  localparam int FSZ            = 26;
  localparam int OSZ            = 16;
  localparam int RST_CYC        = 4;
  localparam int SETTLE_DEFAULT = 8;
  localparam int DW             = 2 * OSZ;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_wr;
  logic [1:0]     cfg_addr;
  logic [31:0]    cfg_wdata;
  logic           ddc_reset;
  logic [FSZ-1:0] ddc_lo_freq;
  logic           ddc_lo_ns_en;
  logic           ddc_out_valid;
  logic [OSZ-1:0] ddc_out_i;
  logic [OSZ-1:0] ddc_out_q;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;
  logic [15:0]    ovf_cnt;
  logic           busy;

  ddc_ctrl #(
    .FSZ(FSZ), .OSZ(OSZ), .RST_CYC(RST_CYC), .SETTLE_DEFAULT(SETTLE_DEFAULT)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ddc_reset(ddc_reset), .ddc_lo_freq(ddc_lo_freq), .ddc_lo_ns_en(ddc_lo_ns_en),
    .ddc_out_valid(ddc_out_valid), .ddc_out_i(ddc_out_i), .ddc_out_q(ddc_out_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  logic [DW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_out   = 0;
  bit  live;
  int  settle_left;
  int  settle_reg_m;
  bit  ns_m;
  int  ovf_model;
  bit  prev_hold;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    live         = 1'b0;
    settle_left  = 0;
    settle_reg_m = SETTLE_DEFAULT;
    ns_m         = 1'b0;
    ovf_model    = 0;
    exp_q.delete();
  endtask

  // Fate of a sample that reaches an enabled controller with no config side effect.
  task automatic model_sample(input logic [DW-1:0] s);
    if (!live) return;
    if (settle_left > 0) begin
      settle_left--;
    end else if (exp_q.size() < 2 || m_ready) begin
      exp_q.push_back(s);
    end else if (ovf_model < 16'hFFFF) begin
      ovf_model++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d,
                           input bit smp, input logic [DW-1:0] s);
    cfg_wr        = 1'b1;
    cfg_addr      = a;
    cfg_wdata     = d;
    ddc_out_valid = smp;
    ddc_out_i     = s[DW-1:OSZ];
    ddc_out_q     = s[OSZ-1:0];
    case (a)
      DDC_REG_CTRL: begin
        if (!d[CTRL_ENABLE]) begin
          live = 1'b0;
          exp_q.delete();
        end else if (!live) begin
          live        = 1'b1;
          settle_left = settle_reg_m;
        end else if (d[CTRL_NS_EN] != ns_m) begin
          settle_left = settle_reg_m;
        end else if (smp) begin
          model_sample(s);
        end
        ns_m = d[CTRL_NS_EN];
        if (d[CTRL_OVF_CLR]) ovf_model = 0;
      end
      DDC_REG_FREQ: begin
        if (live) settle_left = settle_reg_m;
      end
      DDC_REG_SETTLE: begin
        settle_reg_m = int'(d[7:0]);
        if (smp) model_sample(s);
      end
      default: if (smp) model_sample(s);
    endcase
    tick();
    cfg_wr        = 1'b0;
    ddc_out_valid = 1'b0;
  endtask

  task automatic send_sample();
    logic [DW-1:0] s;
    s = DW'($urandom);
    ddc_out_valid = 1'b1;
    ddc_out_i     = s[DW-1:OSZ];
    ddc_out_q     = s[OSZ-1:0];
    model_sample(s);
    tick();
    ddc_out_valid = 1'b0;
  endtask

  task automatic send_samples(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      send_sample();
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic do_enable(input bit ns);
    cfg_write(DDC_REG_CTRL, (32'(ns) << CTRL_NS_EN) | 32'h1, 1'b0, '0);
    check("en_busy", busy, 1);
    check("en_ddc_reset", ddc_reset, 1);
    for (int k = 1; k < RST_CYC; k++) begin
      tick();
      check("rst_hold", ddc_reset, 1);
    end
    tick();
    check("rst_release", ddc_reset, 0);
    check("settle_busy", busy, 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rv_ddc_reset", ddc_reset, 1);
    check("rv_freq", ddc_lo_freq, 0);
    check("rv_ns_en", ddc_lo_ns_en, 0);
    check("rv_m_valid", m_valid, 0);
    check("rv_m_data", m_data, 0);
    check("rv_ovf_cnt", ovf_cnt, 0);
    check("rv_busy", busy, 0);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!reset && live && prev_hold) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
    end
    if (!reset && m_valid && m_ready) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL out_extra: observed data %0h expected no output", m_data);
      end
      if (exp_q.size() > 0) check("out_data", m_data, exp_q.pop_front());
      n_out++;
    end
    prev_hold = !reset && m_valid && !m_ready;
    prev_data = m_data;
  end

  // ---------------- directed sequence ----------------
  int base;

  initial begin
    reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ddc_out_valid = 1'b0; ddc_out_i = '0; ddc_out_q = '0; m_ready = 1'b1;
    prev_hold = 1'b0; prev_data = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_values();

    // Enable, settle 3, ten samples with the consumer always ready.
    cfg_write(DDC_REG_SETTLE, 32'd3, 1'b0, '0);
    do_enable(1'b0);
    base = n_out;
    send_samples(10, 1'b1);
    wait_drain();
    check("run1_count", n_out - base, 7);
    check("run1_busy", busy, 0);
    check("run1_ovf", ovf_cnt, 0);

    // Retune by frequency: no DDC reset, three more samples discarded.
    cfg_write(DDC_REG_FREQ, 32'h0123456, 1'b0, '0);
    check("retune_freq", ddc_lo_freq, 26'h0123456);
    check("retune_busy", busy, 1);
    check("retune_no_rst", ddc_reset, 0);
    base = n_out;
    send_samples(3, 1'b0);
    check("retune_settled", busy, 0);
    send_samples(4, 1'b1);
    wait_drain();
    check("retune_count", n_out - base, 4);

    // Retune by noise-shaping change with a sample on the same cycle.
    base = n_out;
    cfg_write(DDC_REG_CTRL, 32'h5, 1'b1, DW'($urandom));
    check("ns_out", ddc_lo_ns_en, 1);
    send_samples(5, 1'b1);
    wait_drain();
    check("ns_count", n_out - base, 2);
    check("ns_no_rst", ddc_reset, 0);

    // Consumer stalled: two held, three dropped, then drained in order.
    m_ready = 1'b0;
    send_samples(5, 1'b1);
    check("stall_ovf", ovf_cnt, 16'(ovf_model));
    check("stall_valid", m_valid, 1);
    m_ready = 1'b1;
    wait_drain();
    cfg_write(DDC_REG_CTRL, 32'h7, 1'b0, '0);
    check("ovf_clr", ovf_cnt, 16'(ovf_model));

    // Clear and drop in the same cycle: clear wins.
    m_ready = 1'b0;
    send_samples(3, 1'b0);
    check("pre_clr_ovf", ovf_cnt, 16'(ovf_model));
    cfg_write(DDC_REG_CTRL, 32'h7, 1'b1, DW'($urandom));
    check("clr_wins", ovf_cnt, 16'(ovf_model));
    m_ready = 1'b1;
    wait_drain();

    // Disable with two samples buffered flushes the output.
    m_ready = 1'b0;
    send_samples(2, 1'b0);
    check("pre_dis_valid", m_valid, 1);
    cfg_write(DDC_REG_CTRL, 32'h4, 1'b0, '0);
    check("dis_valid", m_valid, 0);
    check("dis_ddc_reset", ddc_reset, 1);
    check("dis_busy", busy, 0);
    m_ready = 1'b1;
    tick();
    check("dis_stays_empty", m_valid, 0);

    // Settle count of zero: first sample after the settle cycle passes.
    cfg_write(DDC_REG_SETTLE, 32'd0, 1'b0, '0);
    do_enable(1'b1);
    tick();
    check("settle0_busy", busy, 0);
    base = n_out;
    send_samples(3, 1'b1);
    wait_drain();
    check("settle0_count", n_out - base, 3);

    // Reset in the middle of SETTLE restores everything, including SETTLE.
    cfg_write(DDC_REG_SETTLE, 32'd5, 1'b0, '0);
    cfg_write(DDC_REG_CTRL, 32'h0, 1'b0, '0);
    do_enable(1'b1);
    send_samples(1, 1'b0);
    model_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values();
    do_enable(1'b0);
    base = n_out;
    send_samples(10, 1'b1);
    wait_drain();
    check("default_settle_count", n_out - base, 10 - SETTLE_DEFAULT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddc_ctrl.md
# ddc_ctrl

Control and output-buffering block for the DDC. It owns the DDC's `reset`, `lo_freq` and `lo_ns_en` inputs and sequences them from a small host register interface: enable, retune and noise-shaping control. After every reset or retune it discards a programmable number of settling samples, then packs the DDC's I/Q outputs into a 2-entry valid/ready buffer for the downstream consumer (the USB/DMA packer), counting any samples it has to drop.

## Interface
Parameters:
- `FSZ`, 26, NCO tuning word width; must match the DDC.
- `OSZ`, 16, DDC output sample width.
- `RST_CYC`, 4, number of cycles `ddc_reset` is held in the RESET state; minimum 1.
- `SETTLE_DEFAULT`, 8, reset value of the settle count register.

Ports:
- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  register write strobe, one cycle per write.
- `cfg_addr`  in  2  register address.
- `cfg_wdata`  in  32  register write data.
- `ddc_reset`  out  1  reset to the DDC.
- `ddc_lo_freq`  out  FSZ  NCO tuning word to the DDC.
- `ddc_lo_ns_en`  out  1  NCO noise-shaping enable to the DDC.
- `ddc_out_valid`  in  1  DDC sample strobe.
- `ddc_out_i`, `ddc_out_q`  in  OSZ  signed DDC sample pair.
- `m_valid`  out  1  downstream data valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  2*OSZ  packed sample: {I, Q}, with I in the upper half.
- `ovf_cnt`  out  16  count of dropped samples; saturates at 16'hFFFF.
- `busy`  out  1  high while in the RESET or SETTLE state.

## Operation
Register map (write-only; the write takes effect on the cycle after `cfg_wr`):
- addr 0, CTRL:
  - bit0 `enable`.
  - bit1 `ovf_clr`, a self-clearing pulse that zeroes `ovf_cnt`.
  - bit2 `ns_en`, driven onto `ddc_lo_ns_en`.
- addr 1, FREQ: bits [FSZ-1:0] drive `ddc_lo_freq`.
- addr 2, SETTLE: bits [7:0] set the number of samples to discard after a reset or retune.
- addr 3: writes are ignored.

State machine:
- IDLE:
  - `ddc_reset`=1; all samples are ignored.
  - A CTRL write with enable=1 → RESET.
- RESET:
  - `ddc_reset`=1 for exactly `RST_CYC` cycles.
  - Then → SETTLE, with the settle counter loaded from the SETTLE register.
- SETTLE:
  - Each `ddc_out_valid` decrements the counter and the sample is discarded.
  - When the counter reaches 0 → RUN.
  - If the loaded count is 0, the transition to RUN happens on the cycle after entry.
- RUN:
  - Each `ddc_out_valid` pushes {I,Q} into the buffer.
  - A FREQ or CTRL.ns_en write updates the output on the next cycle, reloads the settle counter and → SETTLE. The DDC is not reset on a retune.
- From any non-IDLE state, a CTRL write with enable=0 → IDLE.
- A CTRL write with enable=1 while already in RESET, SETTLE or RUN does not restart the sequence; only its other bits apply.

Buffer (2 entries, FIFO order):
- Push while full and not popping in the same cycle: the sample is dropped and `ovf_cnt` increments, saturating.
- Push and pop in the same cycle while full: the push is accepted.
- Entering IDLE flushes the buffer. A retune does not flush it: samples already accepted remain valid.
- `ovf_clr` together with an overflow in the same cycle: the result is `ovf_cnt`=0 (clear wins).

## Timing
- Values during and after reset:
  - `ddc_reset`=1, `ddc_lo_freq`=0, `ddc_lo_ns_en`=0.
  - `m_valid`=0, `m_data`=0, `ovf_cnt`=0, `busy`=0.
  - State is IDLE; SETTLE register = `SETTLE_DEFAULT`.
- Enable write at cycle t:
  - State is RESET at t+1.
  - `ddc_reset` is held high through t+`RST_CYC` and is low from t+`RST_CYC`+1.
  - `busy` is high from t+1.
- Latency: `ddc_out_valid` at cycle n with the buffer empty → `m_valid`=1 at n+1.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- A sample arriving on the same cycle as a retune write is discarded and is not counted toward the settle count.
- `reset` mid-operation returns the block to IDLE on the next cycle, clears the buffer and restores every register to its reset value.

## Structure
- Shared package `ddc_pkg`:
  - Register address constants `DDC_REG_CTRL`/`FREQ`/`SETTLE`.
  - CTRL bit indices.
  - State enum (IDLE, RESET, SETTLE, RUN).
  - `FSZ`/`OSZ` defaults, shared with `ddc`.
- One sub-module, `ddc_out_fifo`: the 2-entry valid/ready buffer, which reports drops through an `ovf` pulse.

## Test plan
- Enable with `RST_CYC`=4, SETTLE=3, then 10 DDC samples → `ddc_reset` high for 4 cycles, the first 3 samples discarded, 7 samples appear in order on `m_data` with `m_ready`=1.
- FREQ write of 26'h0123456 in RUN → `ddc_lo_freq`=26'h0123456 on the next cycle; `busy` rises; the next 3 samples are discarded; `ddc_reset` stays 0.
- `m_ready`=0 while 5 samples arrive → the first 2 are held and `ovf_cnt`=3. Raising `m_ready` returns the 2 held samples in order. A subsequent `ovf_clr` gives `ovf_cnt`=0.
- SETTLE=0 with enable → after the RESET cycles the first sample passes through; `busy` is low on the cycle after RESET ends.
- Enable=0 write with 2 samples buffered → `m_valid`=0 on the next cycle and `ddc_reset`=1. Likewise, `reset` asserted mid-SETTLE restores all reset values.
